// File: rtl/embedded_system_keys_in.sv
// embedded_system_keys_in
//
// Avalon-MM slave for a bank of active-low push-button keys. Each key line
// goes through a two-flop synchronizer. An optional per-bit debounce filter
// is compiled in when the macro EMBEDDED_SYSTEM_KEYS_IN_DEBOUNCE_EN is
// defined. Falling edges (press events) are latched in a W1C edge-capture
// register and can raise a maskable level interrupt.
//
// Register map (word address):
//   0 DATA        RO  filtered key levels
//   1 -           RO  reads 0, writes ignored
//   2 IRQMASK     RW  per-bit interrupt enable
//   3 EDGECAPTURE W1C falling-edge flags
//
// Bus handshake: zero-wait-state Avalon-MM. A write happens on a rising clk
// edge where chipselect=1 and write_n=0. readdata is combinational from
// address and is valid in the same cycle; reads have no side effects.
//
// Parameters:
//   WIDTH           number of key lines (1..32)
//   DEBOUNCE_CYCLES stable-cycle count for the debounce filter (1..2^20)
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   address    register word select
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   in_port    asynchronous key inputs, active-low, idle high
//   readdata   read data, zero-extended above WIDTH
//   irq        active-high level interrupt
module embedded_system_keys_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048576) begin : g_bad_param
    $error("embedded_system_keys_in: parameter out of range");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic             wr;

  // Only the low WIDTH bits of writedata carry register content.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr = chipselect & ~write_n;

  // Synchronizer resets to all-ones (keys idle high) so leaving reset
  // never looks like a key press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef EMBEDDED_SYSTEM_KEYS_IN_DEBOUNCE_EN
  localparam logic [19:0] TERMINAL = 20'(DEBOUNCE_CYCLES - 1);

  logic [19:0] cnt [WIDTH];

  // Each bit counts consecutive cycles where the synchronized input
  // disagrees with the accepted level; any agreement restarts the count,
  // so only a disagreement lasting DEBOUNCE_CYCLES cycles is accepted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!reset_n) begin
        cnt[i]   <= '0;
        level[i] <= 1'b1;
      end else if (sync2[i] == level[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == TERMINAL) begin
        cnt[i]   <= '0;
        level[i] <= sync2[i];
      end else begin
        cnt[i] <= cnt[i] + 20'd1;
      end
    end
  end
`else
  // No filtering: the accepted level is the second synchronizer stage,
  // so an input change is readable two cycles later.
  assign level = sync2;
`endif

  assign fall = prev & ~level;
  assign clr  = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev    <= '1;
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      prev <= level;
      if (wr && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      // Set is OR-ed in after the clear so a same-cycle edge wins.
      edgecap <= (edgecap & ~clr) | fall;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = level;
      2'd2:    readdata[WIDTH-1:0] = irqmask;
      2'd3:    readdata[WIDTH-1:0] = edgecap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_embedded_system_keys_in.sv
// Testbench for embedded_system_keys_in (WIDTH=4, DEBOUNCE_CYCLES=8).
// Expected register values are pushed to exp_q when stimulus is driven and
// popped when the corresponding register is read back.
module tb_embedded_system_keys_in;

  localparam int W = 4;
`ifdef EMBEDDED_SYSTEM_KEYS_IN_DEBOUNCE_EN
  localparam int LVL_LAT = 10;  // 2 sync + 8 stable cycles
`else
  localparam int LVL_LAT = 2;   // 2 sync stages
`endif

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   exp_q[$];

  embedded_system_keys_in #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_read(input logic [1:0] a, input string tag);
    logic [31:0] e;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, readdata, e);
    end
    chipselect = 1'b0;
  endtask

  task automatic pop_irq(input string tag);
    logic [31:0] e;
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, {31'b0, irq}, e);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    push_exp(e);
    pop_read(a, tag);
  endtask

  task automatic chk_irq(input logic e, input string tag);
    push_exp({31'b0, e});
    pop_irq(tag);
  endtask

  // driver: one-cycle write, starting near a falling edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
    writedata  = '0;
  endtask

  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] v;
    logic [W-1:0] ec;

    reset_n    = 1'b0;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cyc(2);
    reset_n = 1'b1;

    // reset state
    rd(2'd0, 32'h0000000F, "rst_data");
    rd(2'd1, 32'h0, "rst_addr1");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_ec");
    chk_irq(1'b0, "rst_irq");

    // ignored writes and chipselect gating
    wr(2'd0, 32'hFFFF_FFF0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0000000F, "ro_data");
    rd(2'd1, 32'h0, "ro_addr1");
    address = 2'd2; writedata = 32'hF; chipselect = 1'b0; write_n = 1'b0;
    cyc(1);
    write_n = 1'b1; writedata = '0;
    rd(2'd2, 32'h0, "cs0_mask");

    // edge capture on bit1 with mask 0x2
    wr(2'd2, 32'h2);
    rd(2'd2, 32'h2, "mask_rb");
    in_port = 4'hD;
    cyc(LVL_LAT - 1);
    rd(2'd0, 32'hF, "data_pre");
    cyc(1);
    rd(2'd0, 32'hD, "data_lat");
    cyc(1);
    rd(2'd3, 32'h2, "ec_b1");
    chk_irq(1'b1, "irq_b1");
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "ec_clr");
    chk_irq(1'b0, "irq_clr");

    // masked edge on bit0, then unmask
    wr(2'd2, 32'h0);
    in_port = 4'hC;
    cyc(LVL_LAT + 1);
    rd(2'd3, 32'h1, "ec_b0");
    chk_irq(1'b0, "irq_masked");
    wr(2'd2, 32'h1);
    chk_irq(1'b1, "irq_unmask");

    // clear of bit2 lands on the same edge its fall is captured
    in_port = 4'h8;
    cyc(LVL_LAT);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h5, "ec_simul");
    wr(2'd3, 32'h5);
    rd(2'd3, 32'h0, "ec_clr2");
    chk_irq(1'b0, "irq_clr2");

    // rising edge on bit3 does not capture
    in_port = 4'h0;
    cyc(LVL_LAT + 1);
    rd(2'd3, 32'h8, "ec_b3");
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "ec_clr3");
    in_port = 4'h8;
    cyc(LVL_LAT + 1);
    rd(2'd3, 32'h0, "ec_rise");
    rd(2'd0, 32'h8, "data_rise");

    // random key patterns against a falling-edge model
    wr(2'd2, 32'hF);
    cur = 4'h8;
    ec  = '0;
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom_range(0, 15));
      in_port = v;
      ec = ec | (cur & ~v);
      push_exp({28'b0, v});
      push_exp({28'b0, ec});
      push_exp({31'b0, |ec});
      cyc(LVL_LAT + 1);
      pop_read(2'd0, "rnd_data");
      pop_read(2'd3, "rnd_ec");
      pop_irq("rnd_irq");
      cur = v;
    end
    wr(2'd3, 32'hF);

`ifdef EMBEDDED_SYSTEM_KEYS_IN_DEBOUNCE_EN
    // debounce: short glitch rejected, held press accepted
    in_port = 4'hF;
    cyc(LVL_LAT + 2);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, "db_idle_ec");
    in_port = 4'hE;
    cyc(5);
    in_port = 4'hF;
    cyc(15);
    rd(2'd0, 32'hF, "glitch_data");
    rd(2'd3, 32'h0, "glitch_ec");
    in_port = 4'hE;
    cyc(LVL_LAT - 1);
    rd(2'd0, 32'hF, "db_pre");
    cyc(1);
    rd(2'd0, 32'hE, "db_data");
    cyc(1);
    rd(2'd3, 32'h1, "db_ec");
`endif

    // reset mid-operation discards pending edges
    in_port = 4'h0;
    cyc(1);
    reset_n = 1'b0;
    cyc(1);
    rd(2'd0, 32'hF, "mrst_data");
    rd(2'd3, 32'h0, "mrst_ec");
    rd(2'd2, 32'h0, "mrst_mask");
    chk_irq(1'b0, "mrst_irq");
    in_port = 4'hF;
    cyc(1);
    reset_n = 1'b1;
    cyc(LVL_LAT + 2);
    rd(2'd3, 32'h0, "post_rst_ec");
    rd(2'd0, 32'hF, "post_rst_data");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
